// File: rtl/mux_nx1_stream_pkg.sv
// mux_pkg: shared types and constants for the mux_nx1_stream slice.
//   state_t     : controller state (IDLE, DIRECT, SCAN)
//   MODE_DIRECT : value of `mode` selecting external-select capture
//   MODE_SCAN   : value of `mode` selecting round-robin capture
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1_stream_if.sv
// mux_nx1_stream_if: sample-source / consumer bundle for mux_nx1_stream.
//   d[N*W]    : packed channel data, channel k at d[k*W +: W]
//   sel[SW]   : direct-mode channel select
//   mode      : 0 = direct, 1 = scan
//   en        : capture enable
//   y[W]      : registered output sample
//   ch[SW]    : channel index of y
//   y_valid   : y/ch holds an unconsumed sample
//   y_ready   : consumer accepts the sample
//   chan_en[N]: per-channel scan enable (only with MUX_SCAN_MASK_EN)
// modport slave  = the mux; modport master = the driver/consumer side.
interface mux_nx1_stream_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);
  logic [N*W-1:0] d;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           en;
  logic [W-1:0]   y;
  logic [SW-1:0]  ch;
  logic           y_valid;
  logic           y_ready;
`ifdef MUX_SCAN_MASK_EN
  logic [N-1:0]   chan_en;

  modport slave  (input  d, sel, mode, en, y_ready, chan_en,
                  output y, ch, y_valid);
  modport master (output d, sel, mode, en, y_ready, chan_en,
                  input  y, ch, y_valid);
`else
  modport slave  (input  d, sel, mode, en, y_ready,
                  output y, ch, y_valid);
  modport master (output d, sel, mode, en, y_ready,
                  input  y, ch, y_valid);
`endif
endinterface

// File: rtl/mux_nx1_stream_next_ch.sv
// mux_next_ch: combinational rotate-priority finder.
//   i_ptr[SW] : search start index
//   i_mask[N] : channel enable mask
//   o_idx[SW] : first enabled channel at or after i_ptr, wrapping
//   o_any     : at least one channel enabled
// Only compiled when MUX_SCAN_MASK_EN is defined; otherwise the scan
// pointer in mux_nx1_stream is a plain wrap counter.
`ifdef MUX_SCAN_MASK_EN
module mux_next_ch #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [SW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic [SW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    int unsigned w_j;
    logic        w_found;
    o_idx   = i_ptr;
    o_any   = |i_mask;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && i_mask[w_j]) begin
        o_idx   = SW'(w_j);
        w_found = 1'b1;
      end
    end
  end
endmodule
`endif

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N-channel, W-bit registered multiplexer with a
// valid/ready output and two selection modes (direct / round-robin scan).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mux_nx1_stream_if.slave (d, sel, mode, en, y_ready in;
//          y, ch, y_valid out; chan_en in with MUX_SCAN_MASK_EN)
// Optional feature macro: MUX_SCAN_MASK_EN (per-channel scan enable).
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  mux_nx1_stream_if.slave bus
);

  state_t        r_state;
  logic [SW-1:0] r_ptr;
  logic [W-1:0]  r_y;
  logic [SW-1:0] r_ch;
  logic          r_valid;

  state_t        w_next_state;
  logic          w_slot_free;
  logic          w_cap;
  logic [SW-1:0] w_scan_ch;
  logic [SW-1:0] w_cap_ch;
  logic [W-1:0]  w_cap_data;
  logic [SW-1:0] w_ptr_inc;
  logic          w_any;
  logic          w_sel_ok;

  // The state register tracks en/mode with one cycle of lag; captures
  // are decided by the registered state, so entry costs one cycle.
  always_comb begin
    w_next_state = IDLE;
    if (bus.en) w_next_state = (bus.mode == MODE_SCAN) ? SCAN : DIRECT;
  end

`ifdef MUX_SCAN_MASK_EN
  // r_ptr is the search start; the captured channel is the first enabled
  // one at or after it. Clearing r_ptr on entry therefore yields the
  // lowest enabled channel, and ptr <- captured+1 yields "next after".
  mux_next_ch #(
    .N (N),
    .SW(SW)
  ) u_next_ch (
    .i_ptr (r_ptr),
    .i_mask(bus.chan_en),
    .o_idx (w_scan_ch),
    .o_any (w_any)
  );

  // Out-of-range selects have no mask bit and still capture zero data.
  always_comb begin
    w_sel_ok = 1'b1;
    for (int unsigned i = 0; i < N; i++)
      if (bus.sel == SW'(i)) w_sel_ok = bus.chan_en[i];
  end
`else
  assign w_scan_ch = r_ptr;
  assign w_any     = 1'b1;
  assign w_sel_ok  = 1'b1;
`endif

  // y_ready feeds capture combinationally so a full slot drains and
  // refills in the same cycle.
  assign w_slot_free = ~r_valid | bus.y_ready;
  assign w_cap_ch    = (r_state == SCAN) ? w_scan_ch : bus.sel;
  assign w_cap       = w_slot_free &
                       (((r_state == DIRECT) & w_sel_ok) |
                        ((r_state == SCAN)   & w_any));
  assign w_ptr_inc   = (w_cap_ch == SW'(N - 1)) ? '0 : w_cap_ch + SW'(1);

  // Unmatched indices (sel >= N) leave the data at zero.
  always_comb begin
    w_cap_data = '0;
    for (int unsigned k = 0; k < N; k++)
      if (w_cap_ch == SW'(k)) w_cap_data = bus.d[k*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_cap) begin
        r_y     <= w_cap_data;
        r_ch    <= w_cap_ch;
        r_valid <= 1'b1;
      end else if (bus.y_ready) begin
        r_valid <= 1'b0;
      end
      if ((w_next_state == SCAN) && (r_state != SCAN))
        r_ptr <= '0;
      else if (w_cap && (r_state == SCAN))
        r_ptr <= w_ptr_inc;
    end
  end

  assign bus.y       = r_y;
  assign bus.ch      = r_ch;
  assign bus.y_valid = r_valid;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb_mux_nx1_stream: directed literal checks plus randomized stimulus,
// with a behavioural model compared against y/ch/y_valid every cycle.
module tb_mux_nx1_stream;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  localparam int ACT_NONE = 0;
  localparam int ACT_DIR  = 1;
  localparam int ACT_SCAN = 2;

  logic clk;
  logic rst;

  mux_nx1_stream_if #(.N(N), .W(W)) bus ();

  mux_nx1_stream #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] ey, input logic [31:0] ech, input logic ev);
    chk({nm, "_y"}, bus.y, ey);
    chk({nm, "_ch"}, bus.ch, ech);
    chk({nm, "_v"}, bus.y_valid, ev);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_y   = '0;
  int           m_ch  = 0;
  bit           m_v   = 0;
  int           m_act = ACT_NONE;
  int           m_nxt = 0;

  function automatic bit ch_on(input int j);
`ifdef MUX_SCAN_MASK_EN
    return bus.chan_en[j];
`else
    return 1'b1;
`endif
  endfunction

  function automatic int first_on(input int start);
    for (int i = 0; i < N; i++)
      if (ch_on((start + i) % N)) return (start + i) % N;
    return -1;
  endfunction

  task automatic model_step();
    int c;
    bit cap;
    int nact;
    if (rst) begin
      m_y = '0; m_ch = 0; m_v = 0; m_act = ACT_NONE; m_nxt = 0;
      return;
    end
    cap = 0;
    c   = 0;
    if (!m_v || bus.y_ready) begin
      if (m_act == ACT_DIR) begin
        c   = int'(bus.sel);
        cap = (c >= N) ? 1'b1 : ch_on(c);
      end else if (m_act == ACT_SCAN) begin
        c   = first_on(m_nxt);
        cap = (c >= 0);
      end
    end
    if (cap) begin
      m_y  = (c < N) ? bus.d[c*W +: W] : '0;
      m_ch = c;
      m_v  = 1;
      if (m_act == ACT_SCAN) m_nxt = (c + 1) % N;
    end else if (bus.y_ready) begin
      m_v = 0;
    end
    nact = !bus.en ? ACT_NONE : (bus.mode ? ACT_SCAN : ACT_DIR);
    if (nact == ACT_SCAN && m_act != ACT_SCAN) m_nxt = 0;
    m_act = nact;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("cyc_y", bus.y, m_y);
    chk("cyc_ch", bus.ch, m_ch);
    chk("cyc_v", bus.y_valid, m_v);
  end

  // ---------------- stimulus ----------------
  task automatic rand_d();
    for (int k = 0; k < N; k++) bus.d[k*W +: W] = W'($urandom);
  endtask

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.mode    = 1'b0;
    bus.sel     = '0;
    bus.y_ready = 1'b1;
`ifdef MUX_SCAN_MASK_EN
    bus.chan_en = '1;
`endif
    rand_d();
    repeat (2) @(negedge clk);
    lit("reset", 0, 0, 1'b0);

    // direct, sel = 2
    rst       = 1'b0;
    bus.d     = 32'hD3C2B1A0;
    bus.sel   = 2'd2;
    bus.mode  = 1'b0;
    bus.en    = 1'b1;
    repeat (2) @(negedge clk);
    lit("direct", 8'hC2, 2, 1'b1);
    @(negedge clk);
    lit("direct_steady", 8'hC2, 2, 1'b1);

    // scan: one more DIRECT capture during entry, then 0,1,2,3,0
    bus.mode = 1'b1;
    @(negedge clk); lit("scan_entry", 8'hC2, 2, 1'b1);
    @(negedge clk); lit("scan0", 8'hA0, 0, 1'b1);
    @(negedge clk); lit("scan1", 8'hB1, 1, 1'b1);
    @(negedge clk); lit("scan2", 8'hC2, 2, 1'b1);
    @(negedge clk); lit("scan3", 8'hD3, 3, 1'b1);
    @(negedge clk); lit("scan_wrap", 8'hA0, 0, 1'b1);
    @(negedge clk); lit("scan_b1", 8'hB1, 1, 1'b1);

    // backpressure while ch = 1
    bus.y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); lit("stall_hold", 8'hB1, 1, 1'b1);
    end
    bus.y_ready = 1'b1;
    @(negedge clk); lit("after_stall", 8'hC2, 2, 1'b1);
    @(negedge clk); lit("after_stall2", 8'hD3, 3, 1'b1);
    @(negedge clk); lit("after_stall3", 8'hA0, 0, 1'b1);

    // mode 1 -> 0 -> 1 with ptr at 1: scan must restart at channel 0
    bus.mode = 1'b0;
    @(negedge clk); lit("toggle_scan", 8'hB1, 1, 1'b1);
    bus.mode = 1'b1;
    @(negedge clk); lit("toggle_dir", 8'hC2, 2, 1'b1);
    @(negedge clk); lit("toggle_restart", 8'hA0, 0, 1'b1);

    // reset mid-stream
    rst = 1'b1;
    @(negedge clk); lit("mid_reset", 0, 0, 1'b0);
    rst = 1'b0;

    // en dropped while a stalled sample is held
    bus.mode = 1'b0;
    bus.sel  = 2'd1;
    repeat (2) @(negedge clk);
    lit("hold_pre", 8'hB1, 1, 1'b1);
    bus.y_ready = 1'b0;
    bus.en      = 1'b0;
    repeat (2) begin
      @(negedge clk); lit("en_off_hold", 8'hB1, 1, 1'b1);
    end
    bus.y_ready = 1'b1;
    @(negedge clk); lit("en_off_drain", 8'hB1, 1, 1'b0);

`ifdef MUX_SCAN_MASK_EN
    bus.chan_en = 4'b1010;
    bus.en      = 1'b1;
    bus.mode    = 1'b1;
    repeat (2) @(negedge clk);
    lit("mask1", 8'hB1, 1, 1'b1);
    @(negedge clk); lit("mask3", 8'hD3, 3, 1'b1);
    @(negedge clk); lit("mask1b", 8'hB1, 1, 1'b1);
    @(negedge clk); lit("mask3b", 8'hD3, 3, 1'b1);
    bus.chan_en = '0;
    @(negedge clk); chk("mask_none_v", bus.y_valid, 0);
    @(negedge clk); chk("mask_none_v2", bus.y_valid, 0);
    bus.chan_en = '1;
`endif

    // randomized phase, checked per cycle against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rand_d();
      rst         = ($urandom_range(0, 99) == 0);
      bus.en      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
      bus.sel     = SW'($urandom);
      bus.y_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_SCAN_MASK_EN
      if ($urandom_range(0, 15) == 0) bus.chan_en = N'($urandom);
`endif
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
